// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller.
// Holds the FSM state encoding, which is also exported on the status port.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        ADJUST  = 2'd3
    } state_e;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge pulse generator.
// Ports:
//   clk    - system clock
//   rst    - asynchronous active-low reset
//   lvl_i  - debounced input level
//   rise_o - high for the single cycle in which lvl_i is 1 and was 0 last cycle
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic lvl_i,
    output logic rise_o
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = lvl_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    // Combinational so the controller can register its response with latency 1.
    assign rise_o = lvl_i & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode/sequencing controller.
// Turns debounced buttons/switches and tick enables into registered one-cycle
// counter commands and digit-blanking controls.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   clr_btn, pause_btn       - debounced button levels (rising edge acts)
//   adj_sw, sel_sw           - adjust mode enable, 1 = minutes / 0 = seconds
//   cnt_tick, adj_tick       - 1 Hz count and 2 Hz adjust enables
//   blink_tick               - toggles the adjust blink phase
//   at_max                   - counter is at 59:59
//   inc_sec_carry, inc_sec_adj, inc_min, clear - one-cycle counter commands
//   blank_min, blank_sec     - display blanking
//   state                    - current FSM state
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter bit STOP_AT_MAX = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_btn,
    input  logic       pause_btn,
    input  logic       adj_sw,
    input  logic       sel_sw,
    input  logic       cnt_tick,
    input  logic       adj_tick,
    input  logic       blink_tick,
    input  logic       at_max,
    output logic       inc_sec_carry,
    output logic       inc_sec_adj,
    output logic       inc_min,
    output logic       clear,
    output logic       blank_min,
    output logic       blank_sec,
    output logic [1:0] state
);

    logic   clr_rise;
    logic   pause_rise;

    state_e state_q, state_d;
    state_e saved_q, saved_d;
    logic   blink_q, blink_d;
    logic   inc_sec_carry_q, inc_sec_carry_d;
    logic   inc_sec_adj_q, inc_sec_adj_d;
    logic   inc_min_q, inc_min_d;
    logic   clear_q, clear_d;
    logic   blank_min_q, blank_min_d;
    logic   blank_sec_q, blank_sec_d;

    edge_detect u_clr_edge (
        .clk    (clk),
        .rst    (rst),
        .lvl_i  (clr_btn),
        .rise_o (clr_rise)
    );

    edge_detect u_pause_edge (
        .clk    (clk),
        .rst    (rst),
        .lvl_i  (pause_btn),
        .rise_o (pause_rise)
    );

    always_comb begin
        state_d         = state_q;
        saved_d         = saved_q;
        blink_d         = blink_q;
        inc_sec_carry_d = 1'b0;
        inc_sec_adj_d   = 1'b0;
        inc_min_d       = 1'b0;
        clear_d         = 1'b0;

        if (clr_rise) begin
            clear_d = 1'b1;
            blink_d = 1'b0;
            if (adj_sw) begin
                state_d = ADJUST;
                saved_d = STOPPED;
            end else begin
                state_d = STOPPED;
            end
        end else if (state_q == ADJUST) begin
            // cnt_tick and pause_rise are dropped while adjusting.
            if (!adj_sw) begin
                state_d = saved_q;
            end else begin
                if (adj_tick) begin
                    if (sel_sw) begin
                        inc_min_d = 1'b1;
                    end else begin
                        inc_sec_adj_d = 1'b1;
                    end
                end
                if (blink_tick) begin
                    blink_d = ~blink_q;
                end
            end
        end else if (adj_sw) begin
            saved_d = state_q;
            state_d = ADJUST;
            blink_d = 1'b0;
        end else begin
            case (state_q)
                STOPPED: if (pause_rise) state_d = RUN;
                PAUSED:  if (pause_rise) state_d = RUN;
                RUN: begin
                    if (cnt_tick) begin
                        if (STOP_AT_MAX && at_max) begin
                            state_d = PAUSED;
                        end else begin
                            inc_sec_carry_d = 1'b1;
                        end
                    end
                    // A coincident tick is still honoured above.
                    if (pause_rise) state_d = PAUSED;
                end
                default: ;
            endcase
        end

        if (state_d != ADJUST) begin
            blink_d = 1'b0;
        end

        // Blanking follows the registered state and phase it is issued with.
        blank_min_d = (state_d == ADJUST) & sel_sw & blink_d;
        blank_sec_d = (state_d == ADJUST) & ~sel_sw & blink_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= STOPPED;
            saved_q         <= STOPPED;
            blink_q         <= 1'b0;
            inc_sec_carry_q <= 1'b0;
            inc_sec_adj_q   <= 1'b0;
            inc_min_q       <= 1'b0;
            clear_q         <= 1'b0;
            blank_min_q     <= 1'b0;
            blank_sec_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            saved_q         <= saved_d;
            blink_q         <= blink_d;
            inc_sec_carry_q <= inc_sec_carry_d;
            inc_sec_adj_q   <= inc_sec_adj_d;
            inc_min_q       <= inc_min_d;
            clear_q         <= clear_d;
            blank_min_q     <= blank_min_d;
            blank_sec_q     <= blank_sec_d;
        end
    end

    assign inc_sec_carry = inc_sec_carry_q;
    assign inc_sec_adj   = inc_sec_adj_q;
    assign inc_min       = inc_min_q;
    assign clear         = clear_q;
    assign blank_min     = blank_min_q;
    assign blank_sec     = blank_sec_q;
    assign state         = state_q;

endmodule
